// File: rtl/ipf_pkg.sv
// Shared IPF definitions: ctrl encodings, sequencer states and datapath defaults.
package ipf_pkg;

  localparam int DATA_W_DEF      = 64;
  localparam int COMPUTE_CYC_DEF = 32;

  typedef enum logic [1:0] {
    CTRL_END   = 2'd0,
    CTRL_START = 2'd1,
    CTRL_HOLD  = 2'd2
  } ipf_ctrl_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_I  = 3'd1,
    S_LOAD_W  = 3'd2,
    S_ARM     = 3'd3,
    S_COMPUTE = 3'd4,
    S_FIN     = 3'd5
  } seq_state_e;

endpackage

// File: rtl/ipf_seq_stream_mux.sv
// Registers the accepted input-row or weight word onto the shared IPF data bus.
module ipf_seq_stream_mux #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_fire,
  input  logic              wt_fire,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] wt_data,
  output logic              ipf_i_valid,
  output logic              ipf_w_valid,
  output logic [DATA_W-1:0] ipf_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ipf_i_valid <= 1'b0;
      ipf_w_valid <= 1'b0;
      ipf_data    <= '0;
    end else begin
      ipf_i_valid <= in_fire;
      ipf_w_valid <= wt_fire;
      // Bus holds its last word between accepts; the valid flags qualify it.
      if (in_fire)      ipf_data <= in_data;
      else if (wt_fire) ipf_data <= wt_data;
    end
  end

endmodule

// File: rtl/ipf_job_sequencer.sv
// Job-level controller feeding IPF rows/weights and driving its START/HOLD/END ctrl.
// Optional IPF_SEQ_PERF_EN adds perf_compute/perf_stall cycle counters.
module ipf_job_sequencer
  import ipf_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ROWS_PER_TILE = 8,
  parameter int W_WORDS       = 4,
  parameter int COMPUTE_CYC   = COMPUTE_CYC_DEF,
  parameter int CNT_W         = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_tiles,
  input  logic [CNT_W-1:0]  cfg_wgroups,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wt_valid,
  output logic              wt_ready,
  input  logic [DATA_W-1:0] wt_data,
  output logic [1:0]        ipf_ctrl,
  output logic              ipf_i_valid,
  output logic              ipf_w_valid,
  output logic [DATA_W-1:0] ipf_data,
  input  logic              ipf_res_valid,
`ifdef IPF_SEQ_PERF_EN
  output logic [31:0]       perf_compute,
  output logic [31:0]       perf_stall,
`endif
  output logic              busy,
  output logic              done
);

  localparam int RW = $clog2(ROWS_PER_TILE + 1);
  localparam int WW = $clog2(W_WORDS + 1);
  localparam int CW = $clog2(COMPUTE_CYC + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS_PER_TILE - 1);
  localparam logic [WW-1:0] WRD_LAST = WW'(W_WORDS - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(COMPUTE_CYC - 1);

  seq_state_e       state, state_d;
  ipf_ctrl_e        ctrl_q, ctrl_d;
  logic             done_q;
  logic [RW-1:0]    row_cnt;
  logic [WW-1:0]    wrd_cnt;
  logic [CW-1:0]    cyc_cnt;
  logic [CNT_W-1:0] grp_cnt, tile_cnt, tiles_q, groups_q;
  logic             in_fire, wt_fire, cfg_fire;
  logic             row_last, wrd_last, cyc_last, grp_last, tile_last;

  assign cfg_ready = (state == S_IDLE);
  assign in_ready  = (state == S_LOAD_I);
  assign wt_ready  = (state == S_LOAD_W);
  assign busy      = (state != S_IDLE);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign in_fire   = in_valid & in_ready;
  assign wt_fire   = wt_valid & wt_ready;
  assign ipf_ctrl  = ctrl_q;
  assign done      = done_q;

  assign row_last  = (row_cnt == ROW_LAST);
  assign wrd_last  = (wrd_cnt == WRD_LAST);
  assign cyc_last  = (cyc_cnt == CYC_LAST);
  assign grp_last  = (grp_cnt == groups_q - CNT_W'(1));
  assign tile_last = (tile_cnt == tiles_q - CNT_W'(1));

  always_comb begin
    state_d = state;
    ctrl_d  = CTRL_HOLD;
    unique case (state)
      S_IDLE:    if (cfg_fire) state_d = S_LOAD_I;
      S_LOAD_I:  if (in_fire && row_last) state_d = S_LOAD_W;
      S_LOAD_W:  if (wt_fire && wrd_last) state_d = S_ARM;
      S_ARM:     state_d = S_COMPUTE;
      S_COMPUTE: begin
        ctrl_d = CTRL_START;
        if (cyc_last) begin
          if (!grp_last)       state_d = S_LOAD_W;
          else if (!tile_last) state_d = S_LOAD_I;
          else                 state_d = S_FIN;
        end
      end
      S_FIN: begin
        ctrl_d  = CTRL_END;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ctrl_q   <= CTRL_HOLD;
      done_q   <= 1'b0;
      row_cnt  <= '0;
      wrd_cnt  <= '0;
      cyc_cnt  <= '0;
      grp_cnt  <= '0;
      tile_cnt <= '0;
      tiles_q  <= '0;
      groups_q <= '0;
    end else begin
      state  <= state_d;
      ctrl_q <= ctrl_d;
      done_q <= (state == S_FIN);
      if (cfg_fire) begin
        tiles_q  <= (cfg_tiles   == '0) ? CNT_W'(1) : cfg_tiles;
        groups_q <= (cfg_wgroups == '0) ? CNT_W'(1) : cfg_wgroups;
        row_cnt  <= '0;
        wrd_cnt  <= '0;
        cyc_cnt  <= '0;
        grp_cnt  <= '0;
        tile_cnt <= '0;
      end
      if (in_fire) row_cnt <= row_last ? '0 : row_cnt + RW'(1);
      if (wt_fire) wrd_cnt <= wrd_last ? '0 : wrd_cnt + WW'(1);
      if (state == S_COMPUTE) begin
        cyc_cnt <= cyc_last ? '0 : cyc_cnt + CW'(1);
        // Group counter wraps at the end of each tile, which advances the tile.
        if (cyc_last) begin
          if (grp_last) begin
            grp_cnt  <= '0;
            tile_cnt <= tile_last ? '0 : tile_cnt + CNT_W'(1);
          end else begin
            grp_cnt  <= grp_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef IPF_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_compute <= '0;
      perf_stall   <= '0;
    end else if (cfg_fire) begin
      perf_compute <= '0;
      perf_stall   <= '0;
    end else begin
      if (state == S_COMPUTE) perf_compute <= perf_compute + 32'd1;
      if ((state == S_LOAD_I && !in_valid) || (state == S_LOAD_W && !wt_valid))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  ipf_seq_stream_mux #(.DATA_W(DATA_W)) u_mux (
    .clk         (clk),
    .rst         (rst),
    .in_fire     (in_fire),
    .wt_fire     (wt_fire),
    .in_data     (in_data),
    .wt_data     (wt_data),
    .ipf_i_valid (ipf_i_valid),
    .ipf_w_valid (ipf_w_valid),
    .ipf_data    (ipf_data)
  );

`ifndef SYNTHESIS
  res_valid_in_compute: assert property (@(posedge clk) disable iff (rst)
    (state == S_COMPUTE) |-> ipf_res_valid)
    else $error("ipf_res_valid low during COMPUTE");
`endif

endmodule

// File: tb/tb_ipf_job_sequencer.sv
// Directed bench for ipf_job_sequencer: scoreboarded IPF stream plus ctrl/done timing.
module tb_ipf_job_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [11:0] cfg_tiles, cfg_wgroups;
  logic        in_valid, in_ready, wt_valid, wt_ready;
  logic [63:0] in_data, wt_data, ipf_data;
  logic [1:0]  ipf_ctrl;
  logic        ipf_i_valid, ipf_w_valid, busy, done;
  logic        ipf_res_valid = 1'b1;
`ifdef IPF_SEQ_PERF_EN
  logic [31:0] perf_compute, perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int i_fwd, w_fwd, windows, run_len, done_cnt, done_cyc, job_groups;
  logic [63:0] exp_i[$];
  logic [63:0] exp_w[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ipf_job_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_tiles     (cfg_tiles),
    .cfg_wgroups   (cfg_wgroups),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .wt_valid      (wt_valid),
    .wt_ready      (wt_ready),
    .wt_data       (wt_data),
    .ipf_ctrl      (ipf_ctrl),
    .ipf_i_valid   (ipf_i_valid),
    .ipf_w_valid   (ipf_w_valid),
    .ipf_data      (ipf_data),
    .ipf_res_valid (ipf_res_valid),
`ifdef IPF_SEQ_PERF_EN
    .perf_compute  (perf_compute),
    .perf_stall    (perf_stall),
`endif
    .busy          (busy),
    .done          (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard and tracks START windows and done pulses.
  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      check("ready_excl", in_ready & wt_ready, 0);
      if (ipf_i_valid) begin
        i_fwd++;
        check("i_queue_nonempty", exp_i.size() != 0, 1);
        if (exp_i.size() != 0) check("i_data", ipf_data, exp_i.pop_front());
      end
      if (ipf_w_valid) begin
        w_fwd++;
        check("w_queue_nonempty", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) check("w_data", ipf_data, exp_w.pop_front());
      end
      if (ipf_ctrl == 2'd1) begin
        if (run_len == 0) begin
          check("start_rows", i_fwd, 8 * (windows / job_groups + 1));
          check("start_wts", w_fwd, 4 * (windows + 1));
        end
        run_len++;
      end else if (run_len != 0) begin
        check("win_len", run_len, 32);
        run_len = 0;
        windows++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_ctrl_end", ipf_ctrl, 0);
      end
    end
  end

  task automatic clear_mon(input int groups);
    i_fwd = 0; w_fwd = 0; windows = 0; run_len = 0; done_cnt = 0;
    job_groups = groups;
    exp_i.delete();
    exp_w.delete();
  endtask

  task automatic drive_streams(input bit iv);
    in_valid = iv;
    in_data  = {$urandom, $urandom};
    wt_valid = 1'b1;
    wt_data  = {$urandom, $urandom};
    if (in_valid && in_ready) exp_i.push_back(in_data);
    if (wt_valid && wt_ready) exp_w.push_back(wt_data);
  endtask

  // mode 0: always valid; 1: in_valid every other cycle; 2: first 3 LOAD_I cycles stalled
  task automatic run_job(input int t, input int g, input int mode, input bit poke_cfg,
                         output int acc_cyc);
    int te, ge, k, stall_left;
    bit iv;
    te = (t == 0) ? 1 : t;
    ge = (g == 0) ? 1 : g;
    clear_mon(ge);
    @(negedge clk);
    check("cfg_ready_idle", cfg_ready, 1);
    cfg_valid   = 1'b1;
    cfg_tiles   = 12'(t);
    cfg_wgroups = 12'(g);
    acc_cyc     = cyc + 1;
    k = 0;
    stall_left = (mode == 2) ? 3 : 0;
    while (done_cnt == 0 && k < 3000) begin
      @(negedge clk);
      k++;
      if (poke_cfg) begin
        cfg_valid = 1'b1; cfg_tiles = 12'd7; cfg_wgroups = 12'd5;
        if (k == 5) check("cfg_ready_busy", cfg_ready, 0);
      end else begin
        cfg_valid = 1'b0;
      end
      iv = 1'b1;
      if (mode == 1) iv = (k % 2 == 0);
      if (mode == 2 && in_ready && stall_left > 0) begin
        iv = 1'b0;
        stall_left--;
      end
      drive_streams(iv);
    end
    cfg_valid = 1'b0; in_valid = 1'b0; wt_valid = 1'b0;
    check("done_seen", done_cnt, 1);
    @(negedge clk);
    @(negedge clk);
    check("done_single", done_cnt, 1);
    check("done_low", done, 0);
    check("busy_after", busy, 0);
    check("rows", i_fwd, 8 * te);
    check("wts", w_fwd, 4 * te * ge);
    check("windows", windows, te * ge);
    check("queues_empty", exp_i.size() + exp_w.size(), 0);
  endtask

  initial begin
    int acc, k;
    rst = 1'b1; cfg_valid = 1'b0; cfg_tiles = '0; cfg_wgroups = '0;
    in_valid = 1'b0; in_data = '0; wt_valid = 1'b0; wt_data = '0;
    clear_mon(1);
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_wt_ready", wt_ready, 0);
    check("rst_ctrl", ipf_ctrl, 2);
    check("rst_valids", {ipf_i_valid, ipf_w_valid}, 0);
    check("rst_data", ipf_data, 0);
    check("rst_busy_done", {busy, done}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_job(1, 1, 0, 1'b0, acc);
    check("done_latency", done_cyc - acc, 46);

    run_job(2, 3, 0, 1'b0, acc);
    run_job(1, 1, 1, 1'b0, acc);
    run_job(0, 0, 0, 1'b1, acc);
    run_job(1, 1, 2, 1'b0, acc);
`ifdef IPF_SEQ_PERF_EN
    check("perf_compute", perf_compute, 32);
    check("perf_stall", perf_stall, 3);
`endif

    // Abort mid-COMPUTE with async reset.
    clear_mon(1);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_tiles = 12'd1; cfg_wgroups = 12'd1;
    k = 0;
    while (run_len < 10 && k < 500) begin
      @(negedge clk);
      k++;
      cfg_valid = 1'b0;
      drive_streams(1'b1);
    end
    check("reach_compute", run_len >= 10, 1);
    rst = 1'b1;
    #1;
    check("abort_ctrl", ipf_ctrl, 2);
    check("abort_busy", busy, 0);
    check("abort_cfg_ready", cfg_ready, 1);
    check("abort_valids", {ipf_i_valid, ipf_w_valid, done}, 0);
    in_valid = 1'b0; wt_valid = 1'b0;
    @(negedge clk);
    clear_mon(1);
    rst = 1'b0;
    @(negedge clk);

    run_job(1, 2, 0, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
